// File: rtl/ifu_axi_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_axi_fetch
// Description : Instruction fetch unit. Owns the PC and fetches one 32-bit
//               instruction at a time over an AXI4-Lite read channel (AR/R).
//               Each instruction is presented to decode through an
//               inst_valid/inst_ready handshake. A redirect from execute
//               replaces the next-fetch PC and squashes any fetch that is in
//               flight or currently presented.
// Ports       : clk, rst (async, active-high)
//               redirect_valid/redirect_pc   - next-PC override from execute
//               inst_valid/inst_ready        - handshake toward decode
//               inst/inst_pc/inst_fault      - presented instruction
//               arvalid/arready/araddr       - AXI read address channel
//               rvalid/rready/rdata/rresp    - AXI read data channel
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_axi_fetch #(
    parameter int              XLEN     = 64,
    parameter int              DATA_W   = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic              inst_fault,
    output logic              arvalid,
    input  logic              arready,
    output logic [XLEN-1:0]   araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    // Set when the PC changed while a read was outstanding: the response that
    // eventually returns belongs to the old PC and must be thrown away.
    logic              kill;

    logic [XLEN-1:0]   redir_pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [31:0]       beat_word;
    logic              unused_redirect_lsbs;

    // Instructions are word aligned; the low two bits of a redirect are dropped.
    assign redir_pc             = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign pc_plus4             = pc + XLEN'(4);

    // A 64-bit beat carries two instructions; pc[2] picks the one we asked for.
    generate
        if (DATA_W == 64) begin : g_word64
            assign beat_word = pc[2] ? rdata[63:32] : rdata[31:0];
        end else begin : g_word32
            assign beat_word = rdata[31:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            arvalid    <= 1'b0;
            araddr     <= RESET_PC;
            rready     <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= 32'h0;
            inst_pc    <= RESET_PC;
            inst_fault <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state   <= S_AR;
                    arvalid <= 1'b1;
                    if (redirect_valid) begin
                        pc     <= redir_pc;
                        araddr <= redir_pc;
                    end else begin
                        araddr <= pc;
                    end
                end

                S_AR: begin
                    // The address already offered must stay on the bus until
                    // accepted, so a redirect only retargets pc and marks the
                    // coming response as stale.
                    if (redirect_valid) begin
                        pc   <= redir_pc;
                        kill <= 1'b1;
                    end
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_R;
                    end
                end

                S_R: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        if (kill || redirect_valid) begin
                            // Stale response: drop it and fetch from the
                            // newest PC (a same-cycle redirect wins).
                            kill    <= 1'b0;
                            arvalid <= 1'b1;
                            state   <= S_AR;
                            if (redirect_valid) begin
                                pc     <= redir_pc;
                                araddr <= redir_pc;
                            end else begin
                                araddr <= pc;
                            end
                        end else begin
                            inst_pc    <= pc;
                            inst_fault <= (rresp != 2'b00);
                            inst       <= (rresp != 2'b00) ? NOP_INST : beat_word;
                            inst_valid <= 1'b1;
                            state      <= S_OUT;
                        end
                    end else if (redirect_valid) begin
                        pc   <= redir_pc;
                        kill <= 1'b1;
                    end
                end

                S_OUT: begin
                    // A redirect voids a same-cycle handshake: pc+4 is not taken.
                    if (redirect_valid) begin
                        pc         <= redir_pc;
                        araddr     <= redir_pc;
                        arvalid    <= 1'b1;
                        inst_valid <= 1'b0;
                        state      <= S_AR;
                    end else if (inst_ready) begin
                        pc         <= pc_plus4;
                        araddr     <= pc_plus4;
                        arvalid    <= 1'b1;
                        inst_valid <= 1'b0;
                        state      <= S_AR;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
